captura_jogada: RTL and testbench
=================================

# captura_jogada

Player-side input front end for the memory game datapath. Synchronizes and debounces the four push-buttons, accepts exactly one clean one-hot press while the control unit is waiting for the player, and delivers it as a registered code plus a one-cycle `jogada_feita` pulse. It is the producer end of the `jogada_feita` / `vez_jogador` / `nova_jogada` handshake consumed by the game control unit.

## Interface
- `DEBOUNCE_CYCLES`, default 50000; stable-level cycles required for both press and release (1 ms at 50 MHz); minimum 2.
- `CW`, default 16; debounce counter width; must satisfy 2^CW > DEBOUNCE_CYCLES.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `botoes`  in  4  raw, asynchronous button levels, active-high.
- `habilita`  in  1  high when the control unit accepts a play (driven by `vez_jogador | nova_jogada`).
- `jogada`  out  4  last accepted one-hot code; reset 4'b0000.
- `jogada_feita`  out  1  one-cycle pulse, `jogada` already valid in the same cycle; reset 0.
- `tem_jogada`  out  1  high while any debounced button is held; reset 0.
- `db_estado`  out  3  current FSM state code; reset 3'd0.

## Operation
- Every `botoes` bit passes through a 2-FF synchronizer; the FSM only sees the synchronized vector `bs`.
- States (codes): ocioso 0, espera_pressao 1, filtra_pressao 2, confirma 3, espera_soltar 4, filtra_soltar 5.
- ocioso: `habilita` -> espera_pressao, else stay.
- espera_pressao: `!habilita` -> ocioso; `bs` one-hot -> filtra_pressao, capture `bs` into candidate, counter cleared; `bs` zero or multi-bit -> stay.
- filtra_pressao: `!habilita` -> ocioso; `bs != candidate` -> espera_pressao; else counter increments; counter == DEBOUNCE_CYCLES-1 -> confirma.
- confirma: load `jogada` <= candidate, assert `jogada_feita`; unconditionally -> espera_soltar.
- espera_soltar: `bs == 0` -> filtra_soltar, counter cleared; else stay (habilita ignored).
- filtra_soltar: `bs != 0` -> espera_soltar; counter == DEBOUNCE_CYCLES-1 -> (`habilita` ? espera_pressao : ocioso).
- `jogada` changes only in confirma; holds otherwise.
- `tem_jogada` = state in {confirma, espera_soltar, filtra_soltar}.
- Invalid state codes 6, 7 -> ocioso.

## Timing
- Synchronizer latency: a `botoes` change sampled at edge k appears on `bs` after edge k+1.
- Press path: `bs` one-hot first seen in espera_pressao at cycle t -> filtra_pressao cycles t+1..t+DEBOUNCE_CYCLES -> confirma (pulse) at cycle t+1+DEBOUNCE_CYCLES.
- Exactly one `jogada_feita` per physical press; a held button never re-triggers.
- Release requires DEBOUNCE_CYCLES consecutive all-zero cycles before the next press is accepted.
- Simultaneous buttons: multi-bit vector never accepted; a second button added during filtra_pressao aborts to espera_pressao.
- `habilita` dropping in filtra_pressao aborts without pulse; dropping after confirma does not suppress release tracking.
- Press already held when `habilita` rises: accepted after full filter (no edge requirement).
- Reset mid-operation: asynchronously to ocioso, counter 0, `jogada` 0, synchronizer flops 0, no pulse.
- Counter saturates at DEBOUNCE_CYCLES-1; never wraps.

## Structure
- Shared include: state codes (3-bit) and default DEBOUNCE_CYCLES value, reused by the top-level and bench.
- Sub-module `sincronizador_2ff` (parameterized width 4), instantiated once.
- Single FSM with Moore outputs; counter and candidate register in the same module.

## Test plan
- DEBOUNCE_CYCLES=4, habilita=1, press botoes=4'b0100 for 20 cycles -> single `jogada_feita` pulse 7 cycles after input change (2 sync + 1 + 4), `jogada`=4'b0100, `tem_jogada` high until 4 cycles after bs clears.
- Bounce: 4'b0010 toggled every 2 cycles for 10 cycles then stable -> exactly one pulse, timed from last stable edge; `jogada`=4'b0010.
- Two buttons 4'b0011 held 20 cycles -> no pulse, db_estado stays 1; release one to 4'b0001 -> pulse with `jogada`=4'b0001.
- habilita=0 with press 4'b1000 -> no pulse, state 0; raise habilita while still held -> pulse after filter, `jogada`=4'b1000.
- Press held 100 cycles -> one pulse only; second press after clean release -> second pulse, `jogada` updated.
- Reset asserted during filtra_pressao and during espera_soltar -> outputs zero immediately, db_estado=0, no pulse after reset release until new filtered press.

Source files
------------

// File: rtl/captura_jogada_pkg.sv
// Shared definitions for the player input front end: FSM state codes,
// default debounce length and a one-hot test used on the synchronized buttons.
package captura_jogada_pkg;

  // 1 ms of stable level at a 50 MHz clock.
  localparam int DEBOUNCE_DEFAULT = 50000;

  // The codes are visible on db_estado, so the encoding is fixed.
  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    ESPERA_PRESSAO = 3'd1,
    FILTRA_PRESSAO = 3'd2,
    CONFIRMA       = 3'd3,
    ESPERA_SOLTAR  = 3'd4,
    FILTRA_SOLTAR  = 3'd5
  } estado_t;

  // True when exactly one bit of the button vector is set.
  function automatic logic um_quente(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/captura_jogada_sincronizador_2ff.sv
// Two-flop synchronizer bringing the asynchronous button levels into the
// clock domain. Both stages clear on reset so no stale press survives it.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second filters it.
  // NOTE: non-blocking assignments make both stages sample the pre-edge values,
  // so the chain really is two flops deep and not collapsed into one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/captura_jogada.sv
// Player input front end: synchronizes and debounces the four buttons and,
// while the control unit is waiting for a play, accepts one clean one-hot
// press and presents it on jogada together with a one-cycle jogada_feita.
module captura_jogada
  import captura_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CW              = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       tem_jogada,
  output logic [2:0] db_estado
);

  // Last counter value of a debounce window; the counter never goes past it.
  localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CYCLES - 1);

  estado_t       estado;
  estado_t       proximo;
  logic [3:0]    bs;
  logic [3:0]    candidato;
  logic [CW-1:0] contador;
  logic          fim;

  sincronizador_2ff #(.WIDTH(4)) u_sincronizador (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (bs)
  );

  assign fim = (contador == ULTIMO);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Next-state logic: press filter, then release filter, gated by habilita
  // only on the press side so a release is always tracked to completion.
  always_comb begin
    // NOTE: defaulting to the current state before the case keeps every path
    // assigned, so no latch is inferred for proximo.
    proximo = estado;
    case (estado)
      OCIOSO:
        if (habilita) proximo = ESPERA_PRESSAO;
      ESPERA_PRESSAO:
        if (!habilita)        proximo = OCIOSO;
        else if (um_quente(bs)) proximo = FILTRA_PRESSAO;
      FILTRA_PRESSAO:
        if (!habilita)            proximo = OCIOSO;
        else if (bs != candidato) proximo = ESPERA_PRESSAO;
        else if (fim)             proximo = CONFIRMA;
      CONFIRMA:
        proximo = ESPERA_SOLTAR;
      ESPERA_SOLTAR:
        if (bs == 4'b0000) proximo = FILTRA_SOLTAR;
      FILTRA_SOLTAR:
        if (bs != 4'b0000) proximo = ESPERA_SOLTAR;
        else if (fim)      proximo = habilita ? ESPERA_PRESSAO : OCIOSO;
      default:
        proximo = OCIOSO;
    endcase
  end

  // Debounce counter, press candidate and accepted code. jogada is loaded on
  // the edge that enters CONFIRMA so it is already valid during the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador  <= '0;
      candidato <= 4'b0000;
      jogada    <= 4'b0000;
    end else begin
      case (estado)
        ESPERA_PRESSAO:
          if (habilita && um_quente(bs)) begin
            candidato <= bs;
            contador  <= '0;
          end
        FILTRA_PRESSAO:
          if (habilita && (bs == candidato)) begin
            if (fim) jogada   <= candidato;
            else     contador <= contador + CW'(1);
          end
        ESPERA_SOLTAR:
          if (bs == 4'b0000) contador <= '0;
        FILTRA_SOLTAR:
          if ((bs == 4'b0000) && !fim) contador <= contador + CW'(1);
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    jogada_feita = (estado == CONFIRMA);
    tem_jogada   = (estado == CONFIRMA) || (estado == ESPERA_SOLTAR) ||
                   (estado == FILTRA_SOLTAR);
    db_estado    = estado;
  end

endmodule

// File: tb/tb_captura_jogada.sv
// Bench for captura_jogada: directed scenarios followed by random button and
// habilita traffic, every cycle compared against a run-length reference model.
module tb_captura_jogada;
  import captura_jogada_pkg::*;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       tem_jogada;
  logic [2:0] db_estado;

  captura_jogada #(.DEBOUNCE_CYCLES(D), .CW(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .habilita     (habilita),
    .jogada       (jogada),
    .jogada_feita (jogada_feita),
    .tem_jogada   (tem_jogada),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: the synchronizer is a two-deep delay of botoes; the
  // filter is described by how many consecutive cycles the current level has
  // been seen (streak while listening for a press, rel while releasing).
  typedef enum {M_IDLE, M_LISTEN, M_HELD} fase_t;
  fase_t      fase;
  int         streak;
  int         rel;
  logic [3:0] cand, m_jog, s1, s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fase = M_IDLE; streak = 0; rel = 0;
    cand = 4'b0; m_jog = 4'b0; s1 = 4'b0; s2 = 4'b0;
  endtask

  // Advance the model by one clock edge using the pre-edge inputs.
  task automatic model_edge();
    logic [3:0] b;
    b = s2;
    case (fase)
      M_IDLE:
        if (habilita) begin fase = M_LISTEN; streak = 0; end
      M_LISTEN:
        if (!habilita) fase = M_IDLE;
        else if (streak == 0) begin
          if ($countones(b) == 1) begin cand = b; streak = 1; end
        end
        else if (b != cand) streak = 0;
        else if (streak == D) begin fase = M_HELD; rel = -1; m_jog = cand; end
        else streak++;
      M_HELD:
        if (rel == -1) rel = 0;
        else if (rel == 0) begin
          if (b == 4'b0) rel = 1;
        end
        else if (b != 4'b0) rel = 0;
        else if (rel == D) begin
          if (habilita) begin fase = M_LISTEN; streak = 0; end
          else fase = M_IDLE;
        end
        else rel++;
      default: fase = M_IDLE;
    endcase
    s2 = s1;
    s1 = botoes;
  endtask

  function automatic logic [2:0] exp_estado();
    if (fase == M_IDLE)   return 3'd0;
    if (fase == M_LISTEN) return (streak == 0) ? 3'd1 : 3'd2;
    if (rel == -1)        return 3'd3;
    return (rel == 0) ? 3'd4 : 3'd5;
  endfunction

  // One clock: model advances on the edge, outputs are compared on the
  // following falling edge, where new inputs may then be driven.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (jogada_feita) pulses++;
    check("jogada", jogada, m_jog);
    check("jogada_feita", jogada_feita, (fase == M_HELD) && (rel == -1));
    check("tem_jogada", tem_jogada, fase == M_HELD);
    check("db_estado", db_estado, exp_estado());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_jogada"}, jogada, 4'b0000);
    check({tag, "_feita"}, jogada_feita, 1'b0);
    check({tag, "_tem"}, tem_jogada, 1'b0);
    check({tag, "_estado"}, db_estado, OCIOSO);
    model_reset();
    repeat (2) begin @(posedge clock); model_reset(); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    int r;
    int dur;

    reset = 1'b1; botoes = 4'b0; habilita = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_jogada", jogada, 4'b0000);
    check("reset_feita", jogada_feita, 1'b0);
    check("reset_tem", tem_jogada, 1'b0);
    check("reset_estado", db_estado, 3'd0);
    reset = 1'b0;

    // Clean press: pulse D+3 clocks after the input change.
    habilita = 1'b1;
    run(3);
    botoes = 4'b0100; pulses = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (jogada_feita && lat < 0) lat = i;
    end
    check("press_latency", lat, D + 3);
    check("press_pulses", pulses, 1);
    check("press_code", jogada, 4'b0100);
    botoes = 4'b0; run(12);
    check("release_tem", tem_jogada, 1'b0);

    // Bouncing contact: only the final stable level counts.
    pulses = 0; lat = -1;
    for (int i = 1; i <= 28; i++) begin
      if (i <= 8) botoes = (((i - 1) / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      else        botoes = 4'b0010;
      step();
      if (jogada_feita && lat < 0) lat = i;
    end
    check("bounce_latency", lat, 8 + D + 3);
    check("bounce_pulses", pulses, 1);
    check("bounce_code", jogada, 4'b0010);
    botoes = 4'b0; run(12);

    // Two buttons together are never accepted; dropping one is.
    pulses = 0;
    botoes = 4'b0011; run(20);
    check("multi_pulses", pulses, 0);
    check("multi_estado", db_estado, 3'd1);
    botoes = 4'b0001; run(20);
    check("single_pulses", pulses, 1);
    check("single_code", jogada, 4'b0001);
    botoes = 4'b0; run(12);

    // Press while disabled, then enable while still held.
    habilita = 1'b0; run(4);
    pulses = 0;
    botoes = 4'b1000; run(10);
    check("disabled_pulses", pulses, 0);
    check("disabled_estado", db_estado, 3'd0);
    habilita = 1'b1; run(15);
    check("enabled_pulses", pulses, 1);
    check("enabled_code", jogada, 4'b1000);
    botoes = 4'b0; run(12);

    // Long hold gives one pulse; a second press after release gives another.
    pulses = 0;
    botoes = 4'b0100; run(100);
    check("hold_pulses", pulses, 1);
    botoes = 4'b0; run(12);
    botoes = 4'b0001; run(15);
    check("second_pulses", pulses, 2);
    check("second_code", jogada, 4'b0001);
    botoes = 4'b0; run(12);

    // Reset while filtering a press, button still held afterwards.
    botoes = 4'b0010; run(4);
    check("pre_reset_estado", db_estado, 3'd2);
    async_reset("rst_filtra");
    pulses = 0; run(20);
    check("rst_filtra_pulses", pulses, 1);
    botoes = 4'b0; run(12);

    // Reset while waiting for release, button let go at the same time.
    botoes = 4'b1000; run(9);
    check("pre_reset2_estado", db_estado, 3'd4);
    botoes = 4'b0;
    async_reset("rst_soltar");
    pulses = 0; run(20);
    check("rst_soltar_pulses", pulses, 0);

    // Random traffic against the model.
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      botoes = 4'b0001 << $urandom_range(0, 3);
      else if (r < 7) botoes = 4'b0000;
      else            botoes = 4'($urandom);
      habilita = ($urandom_range(0, 3) != 0);
      dur = $urandom_range(1, 12);
      run(dur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
